wash_sequencer: RTL and testbench
=================================

// Module: wash_sequencer
// PURPOSE
//  Program controller for the washing machine. Sequences fill/wash/drain/rinse/spin/done phases
//  from debounced button pulses and a 1 Hz tick. Owns the power, time and water values that the
//  seven-segment display block shows; its outputs wire straight to power_light, current_time,
//  total_time and current_water there.
// PARAMETERS
//  WASH_T    10  wash phase length, ticks
//  RINSE_T    6  rinse phase length, ticks
//  SPIN_T     4  spin phase length, ticks
//  WATER_LVL 20  fill target level, 0..99
//  FILL_RATE  5  level change per tick during fill/drain; WATER_LVL must be a multiple of it
//  BUZZ_T     3  buzzer duration in DONE, ticks
// PORTS
//  clk            in   1  system clock
//  rst_n          in   1  asynchronous active-low reset
//  tick_1s        in   1  one-cycle 1 Hz pulse
//  power_btn      in   1  one-cycle pulse, toggles power
//  start_btn      in   1  one-cycle pulse, start / pause / resume
//  mode           in   2  0 full, 1 wash only, 2 rinse+spin, 3 spin only
//  power_light    out  1  1 while powered
//  running        out  1  1 while a program advances (not paused)
//  current_time   out  7  remaining timed ticks of the program
//  total_time     out  7  total timed ticks of the selected program
//  current_water  out  7  simulated water level
//  phase_led      out  3  {spin,rinse,wash}, 1 while in that timed phase
//  buzzer         out  1  1 during DONE
// BEHAVIOUR
//  - All outputs are registered. Async reset -> state OFF, all outputs 0.
//  - States: OFF, IDLE, FILL, WASH, DRAIN, RINSE, SPIN, DONE. Pause is a separate flag, not a state.
//  - OFF: power_btn -> IDLE with power_light=1 and total_time=current_time=sum(mode).
//    sum(mode) values: full = WASH_T+RINSE_T+SPIN_T; wash = WASH_T; rinse+spin = RINSE_T+SPIN_T;
//    spin = SPIN_T. Defaults give 20 / 10 / 10 / 4.
//  - power_btn in any non-OFF state -> OFF next cycle; every output cleared; pause cleared.
//  - IDLE: a mode change reloads total_time and current_time the next cycle.
//  - IDLE + start_btn -> first phase, running=1. Full, wash and rinse+spin start in FILL.
//    Spin-only starts in SPIN.
//  - Mode is latched at start. Mode changes outside IDLE are ignored.
//  - Non-IDLE, non-DONE state + start_btn toggles pause. Paused: running=0, no state change,
//    ticks ignored.
//  - Progress happens only on an unpaused tick_1s. Each update is visible the cycle after the tick.
//  - FILL: water += FILL_RATE. When water reaches WATER_LVL, go to WASH or RINSE, chosen by the
//    internal rinse_pending flag.
//  - WASH/RINSE/SPIN: each runs a phase counter loaded with its _T value on entry. Each tick
//    decrements the phase counter and current_time. At 0: WASH->DRAIN, RINSE->DRAIN, SPIN->DONE.
//  - DRAIN: water -= FILL_RATE, saturating at 0. At 0, the next state follows the mode:
//    full after wash -> FILL with rinse_pending; wash-only -> DONE; after rinse -> SPIN.
//  - FILL and DRAIN are untimed: current_time holds its value through them.
//  - DONE: buzzer=1, running=0, current_time=0 for BUZZ_T ticks, then IDLE with times reloaded.
//    start_btn in DONE is ignored.
//  - Simultaneous events: power_btn beats start_btn beats tick_1s. A tick that lands in the same
//    cycle as a start_btn pause is not counted.
//  - current_time never underflows. total_time stays constant from start until IDLE is re-entered.
// TESTING
//  1. Reset, power_btn, mode=0, start -> total_time=20. Water 5,10,15,20 over 4 ticks. WASH for
//     10 ticks (phase_led=001). Drain 4 ticks. Refill 4 ticks. RINSE 6 ticks (010). Drain 4 ticks.
//     SPIN 4 ticks (100). DONE with buzzer for 3 ticks, then IDLE with current_time=20.
//  2. mode=3, start -> SPIN immediately, water stays 0. current_time 4->0 over 4 ticks, then DONE.
//  3. In WASH with current_time=15: start pulse, 5 ticks -> values frozen and running=0.
//     Second start pulse -> resumes at 15.
//  4. power_btn mid-RINSE -> next cycle power_light=0 and every output is 0. power_btn again ->
//     IDLE with the mode's totals.
//  5. Mode switched 0->2 in IDLE -> total_time=10 next cycle. Switching mode mid-WASH changes
//     nothing.
//  6. rst_n asserted mid-FILL, asynchronous to clk -> outputs 0 immediately. Same-cycle
//     start_btn and tick_1s in WASH -> paused and the tick is not counted.

Source files
------------

// File: rtl/wash_sequencer.sv
// -----------------------------------------------------------------------------
// wash_sequencer
//   Washing-machine program controller. Steps through fill / wash / drain /
//   rinse / spin / done phases, driven by one-cycle button pulses and a 1 Hz
//   tick. It also owns the values shown on the seven-segment display block.
//
// Ports
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   tick_1s        one-cycle 1 Hz pulse; progress happens only on this
//   power_btn      one-cycle pulse, toggles power
//   start_btn      one-cycle pulse, start / pause / resume
//   mode[1:0]      0 full, 1 wash only, 2 rinse+spin, 3 spin only
//   power_light    1 while powered
//   running        1 while a program advances (not paused)
//   current_time   remaining timed ticks of the program
//   total_time     total timed ticks of the selected program
//   current_water  simulated water level
//   phase_led      {spin,rinse,wash}, 1 while in that timed phase
//   buzzer         1 during DONE
// -----------------------------------------------------------------------------
module wash_sequencer #(
   parameter int WASH_T    = 10,
   parameter int RINSE_T   = 6,
   parameter int SPIN_T    = 4,
   parameter int WATER_LVL = 20,
   parameter int FILL_RATE = 5,
   parameter int BUZZ_T    = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick_1s,
   input  logic       power_btn,
   input  logic       start_btn,
   input  logic [1:0] mode,
   output logic       power_light,
   output logic       running,
   output logic [6:0] current_time,
   output logic [6:0] total_time,
   output logic [6:0] current_water,
   output logic [2:0] phase_led,
   output logic       buzzer
);

   typedef enum logic [2:0] {
      S_OFF, S_IDLE, S_FILL, S_WASH, S_DRAIN, S_RINSE, S_SPIN, S_DONE
   } state_t;

   localparam logic [6:0] WASH_C  = 7'(WASH_T);
   localparam logic [6:0] RINSE_C = 7'(RINSE_T);
   localparam logic [6:0] SPIN_C  = 7'(SPIN_T);
   localparam logic [6:0] LVL_C   = 7'(WATER_LVL);
   localparam logic [6:0] RATE_C  = 7'(FILL_RATE);
   localparam logic [6:0] BUZZ_C  = 7'(BUZZ_T);

   // Timed length of a program; fill and drain contribute nothing.
   function automatic logic [6:0] prog_time(input logic [1:0] m);
      case (m)
         2'd0:    return 7'(WASH_T + RINSE_T + SPIN_T);
         2'd1:    return WASH_C;
         2'd2:    return 7'(RINSE_T + SPIN_T);
         default: return SPIN_C;
      endcase
   endfunction

   state_t     state_q, state_d;
   logic       paused_q, paused_d;
   logic       rinse_pending_q, rinse_pending_d;
   logic [1:0] mode_q, mode_d;
   logic [6:0] phase_cnt_q, phase_cnt_d;
   logic [6:0] buzz_cnt_q, buzz_cnt_d;
   logic       power_light_q, power_light_d;
   logic       running_q, running_d;
   logic [6:0] current_time_q, current_time_d;
   logic [6:0] total_time_q, total_time_d;
   logic [6:0] current_water_q, current_water_d;
   logic [2:0] phase_led_q, phase_led_d;
   logic       buzzer_q, buzzer_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= S_OFF;
         paused_q        <= 1'b0;
         rinse_pending_q <= 1'b0;
         mode_q          <= 2'd0;
         phase_cnt_q     <= 7'd0;
         buzz_cnt_q      <= 7'd0;
         power_light_q   <= 1'b0;
         running_q       <= 1'b0;
         current_time_q  <= 7'd0;
         total_time_q    <= 7'd0;
         current_water_q <= 7'd0;
         phase_led_q     <= 3'd0;
         buzzer_q        <= 1'b0;
      end else begin
         state_q         <= state_d;
         paused_q        <= paused_d;
         rinse_pending_q <= rinse_pending_d;
         mode_q          <= mode_d;
         phase_cnt_q     <= phase_cnt_d;
         buzz_cnt_q      <= buzz_cnt_d;
         power_light_q   <= power_light_d;
         running_q       <= running_d;
         current_time_q  <= current_time_d;
         total_time_q    <= total_time_d;
         current_water_q <= current_water_d;
         phase_led_q     <= phase_led_d;
         buzzer_q        <= buzzer_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      paused_d        = paused_q;
      rinse_pending_d = rinse_pending_q;
      mode_d          = mode_q;
      phase_cnt_d     = phase_cnt_q;
      buzz_cnt_d      = buzz_cnt_q;
      current_time_d  = current_time_q;
      total_time_d    = total_time_q;
      current_water_d = current_water_q;

      if (power_btn) begin
         // Power has top priority over start and tick.
         paused_d        = 1'b0;
         rinse_pending_d = 1'b0;
         phase_cnt_d     = 7'd0;
         buzz_cnt_d      = 7'd0;
         current_water_d = 7'd0;
         if (state_q == S_OFF) begin
            state_d        = S_IDLE;
            total_time_d   = prog_time(mode);
            current_time_d = prog_time(mode);
         end else begin
            state_d        = S_OFF;
            total_time_d   = 7'd0;
            current_time_d = 7'd0;
         end
      end else begin
         case (state_q)
            S_OFF: ;
            S_IDLE: begin
               // Times track the mode selector continuously while idle.
               paused_d       = 1'b0;
               total_time_d   = prog_time(mode);
               current_time_d = prog_time(mode);
               if (start_btn) begin
                  mode_d          = mode;
                  rinse_pending_d = (mode == 2'd2);
                  if (mode == 2'd3) begin
                     state_d     = S_SPIN;
                     phase_cnt_d = SPIN_C;
                  end else begin
                     state_d = S_FILL;
                  end
               end
            end
            S_DONE: begin
               // start_btn is deliberately ignored here.
               current_time_d = 7'd0;
               if (tick_1s) begin
                  if (buzz_cnt_q <= 7'd1) begin
                     state_d        = S_IDLE;
                     buzz_cnt_d     = 7'd0;
                     total_time_d   = prog_time(mode);
                     current_time_d = prog_time(mode);
                  end else begin
                     buzz_cnt_d = buzz_cnt_q - 7'd1;
                  end
               end
            end
            default: begin
               // Active phases. A start pulse swallows a coincident tick.
               if (start_btn) begin
                  paused_d = !paused_q;
               end else if (tick_1s && !paused_q) begin
                  case (state_q)
                     S_FILL: begin
                        current_water_d = current_water_q + RATE_C;
                        if (current_water_d >= LVL_C) begin
                           if (rinse_pending_q) begin
                              state_d     = S_RINSE;
                              phase_cnt_d = RINSE_C;
                           end else begin
                              state_d     = S_WASH;
                              phase_cnt_d = WASH_C;
                           end
                        end
                     end
                     S_DRAIN: begin
                        current_water_d = (current_water_q > RATE_C) ?
                                          current_water_q - RATE_C : 7'd0;
                        if (current_water_d == 7'd0) begin
                           if (rinse_pending_q) begin
                              state_d     = S_SPIN;
                              phase_cnt_d = SPIN_C;
                           end else if (mode_q == 2'd0) begin
                              state_d         = S_FILL;
                              rinse_pending_d = 1'b1;
                           end else begin
                              state_d        = S_DONE;
                              buzz_cnt_d     = BUZZ_C;
                              current_time_d = 7'd0;
                           end
                        end
                     end
                     default: begin
                        // WASH / RINSE / SPIN share the countdown.
                        current_time_d = (current_time_q != 7'd0) ?
                                         current_time_q - 7'd1 : 7'd0;
                        phase_cnt_d    = (phase_cnt_q != 7'd0) ?
                                         phase_cnt_q - 7'd1 : 7'd0;
                        if (phase_cnt_q <= 7'd1) begin
                           if (state_q == S_SPIN) begin
                              state_d        = S_DONE;
                              buzz_cnt_d     = BUZZ_C;
                              current_time_d = 7'd0;
                           end else begin
                              state_d = S_DRAIN;
                           end
                        end
                     end
                  endcase
               end
            end
         endcase
      end

      // Status outputs are decoded from the next state so they register
      // alongside it.
      power_light_d = (state_d != S_OFF);
      running_d     = !paused_d && (state_d inside {S_FILL, S_WASH, S_DRAIN,
                                                    S_RINSE, S_SPIN});
      phase_led_d   = {state_d == S_SPIN, state_d == S_RINSE, state_d == S_WASH};
      buzzer_d      = (state_d == S_DONE);
   end

   assign power_light   = power_light_q;
   assign running       = running_q;
   assign current_time  = current_time_q;
   assign total_time    = total_time_q;
   assign current_water = current_water_q;
   assign phase_led     = phase_led_q;
   assign buzzer        = buzzer_q;

endmodule

// File: tb/tb_wash_sequencer.sv
// -----------------------------------------------------------------------------
// tb_wash_sequencer
//   Directed, table-driven bench for wash_sequencer. Each table record is one
//   clock cycle of button/tick/mode stimulus plus the outputs expected after
//   that edge. Asynchronous reset is exercised by a hand-written sequence.
// -----------------------------------------------------------------------------
module tb_wash_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tick_1s = 1'b0;
   logic       power_btn = 1'b0;
   logic       start_btn = 1'b0;
   logic [1:0] mode = 2'd0;
   logic       power_light, running, buzzer;
   logic [6:0] current_time, total_time, current_water;
   logic [2:0] phase_led;

   int checks = 0;
   int failures = 0;

   wash_sequencer dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .tick_1s       (tick_1s),
      .power_btn     (power_btn),
      .start_btn     (start_btn),
      .mode          (mode),
      .power_light   (power_light),
      .running       (running),
      .current_time  (current_time),
      .total_time    (total_time),
      .current_water (current_water),
      .phase_led     (phase_led),
      .buzzer        (buzzer)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic       pwr, st, tk;
      logic [1:0] md;
      logic [26:0] exp;   // {pl, run, cur, tot, water, led, buz}
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input string nm, input logic p, input logic s,
                               input logic t, input int m, input logic pl,
                               input logic run, input int cur, input int tot,
                               input int wat, input int led, input logic buz);
      vec_t v;
      v.name = nm;
      v.pwr  = p;
      v.st   = s;
      v.tk   = t;
      v.md   = 2'(m);
      v.exp  = {pl, run, 7'(cur), 7'(tot), 7'(wat), 3'(led), buz};
      return v;
   endfunction

   task automatic add(input string nm, input logic p, input logic s,
                      input logic t, input int m, input logic pl,
                      input logic run, input int cur, input int tot,
                      input int wat, input int led, input logic buz);
      vecs.push_back(mk(nm, p, s, t, m, pl, run, cur, tot, wat, led, buz));
   endtask

   function automatic logic [26:0] actual();
      return {power_light, running, current_time, total_time, current_water,
              phase_led, buzzer};
   endfunction

   task automatic compare(input string nm, input logic [26:0] exp);
      logic [26:0] act;
      act = actual();
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got pl=%0b run=%0b cur=%0d tot=%0d wat=%0d led=%03b buz=%0b, need pl=%0b run=%0b cur=%0d tot=%0d wat=%0d led=%03b buz=%0b",
                  nm, act[26], act[25], act[24:18], act[17:11], act[10:4], act[3:1], act[0],
                  exp[26], exp[25], exp[24:18], exp[17:11], exp[10:4], exp[3:1], exp[0]);
      end else begin
         $display("ok   %s: cur=%0d tot=%0d wat=%0d led=%03b run=%0b buz=%0b",
                  nm, act[24:18], act[17:11], act[10:4], act[3:1], act[25], act[0]);
      end
   endtask

   // Drive one cycle of stimulus, then sample 1 ns after the rising edge.
   task automatic apply(input vec_t v);
      power_btn = v.pwr;
      start_btn = v.st;
      tick_1s   = v.tk;
      mode      = v.md;
      @(posedge clk);
      #1;
      power_btn = 1'b0;
      start_btn = 1'b0;
      tick_1s   = 1'b0;
      compare(v.name, v.exp);
   endtask

   initial begin
      // ---- Test 1: full program (mode 0), plus idle mode reload ----
      add("pwr_on",     1,0,0,0, 1,0,20,20,0,0,0);
      add("idle_mode2", 0,0,0,2, 1,0,10,10,0,0,0);
      add("idle_mode0", 0,0,0,0, 1,0,20,20,0,0,0);
      add("start_full", 0,1,0,0, 1,1,20,20,0,0,0);
      for (int i = 1; i <= 4; i++)  add("fill",   0,0,1,0, 1,1,20,20,5*i,(i==4)?1:0,0);
      add("hold_wash",  0,0,0,0, 1,1,20,20,20,1,0);
      for (int i = 1; i <= 10; i++) add("wash",   0,0,1,0, 1,1,20-i,20,20,(i==10)?0:1,0);
      for (int i = 1; i <= 4; i++)  add("drain",  0,0,1,0, 1,1,10,20,20-5*i,0,0);
      for (int i = 1; i <= 4; i++)  add("refill", 0,0,1,0, 1,1,10,20,5*i,(i==4)?2:0,0);
      for (int i = 1; i <= 6; i++)  add("rinse",  0,0,1,0, 1,1,10-i,20,20,(i==6)?0:2,0);
      for (int i = 1; i <= 4; i++)  add("drain2", 0,0,1,0, 1,1,4,20,20-5*i,(i==4)?4:0,0);
      for (int i = 1; i <= 4; i++)  add("spin",   0,0,1,0, 1,(i<4),4-i,20,0,(i<4)?4:0,(i==4));
      add("done_start", 0,1,0,0, 1,0,0,20,0,0,1);
      for (int i = 1; i <= 3; i++)  add("done",   0,0,1,0, 1,0,(i==3)?20:0,20,0,0,(i<3));
      // ---- Test 2: spin only ----
      add("idle_mode3", 0,0,0,3, 1,0,4,4,0,0,0);
      add("start_spin", 0,1,0,3, 1,1,4,4,0,4,0);
      for (int i = 1; i <= 4; i++)  add("spin_only", 0,0,1,3, 1,(i<4),4-i,4,0,(i<4)?4:0,(i==4));
      for (int i = 1; i <= 3; i++)  add("done_m3",   0,0,1,3, 1,0,(i==3)?4:0,4,0,0,(i<3));
      // ---- Test 3/5/6: pause with coincident tick, mode change mid-run ----
      add("idle_mode0b", 0,0,0,0, 1,0,20,20,0,0,0);
      add("start_full2", 0,1,0,0, 1,1,20,20,0,0,0);
      for (int i = 1; i <= 4; i++)  add("fill2",  0,0,1,0, 1,1,20,20,5*i,(i==4)?1:0,0);
      for (int i = 1; i <= 5; i++)  add("wash2",  0,0,1,0, 1,1,20-i,20,20,1,0);
      add("pause_tick", 0,1,1,0, 1,0,15,20,20,1,0);
      for (int i = 1; i <= 5; i++)  add("paused", 0,0,1,1, 1,0,15,20,20,1,0);
      add("resume",     0,1,0,1, 1,1,15,20,20,1,0);
      for (int i = 6; i <= 10; i++) add("wash3",  0,0,1,1, 1,1,20-i,20,20,(i==10)?0:1,0);
      for (int i = 1; i <= 4; i++)  add("drain3", 0,0,1,1, 1,1,10,20,20-5*i,0,0);
      for (int i = 1; i <= 4; i++)  add("refill3",0,0,1,1, 1,1,10,20,5*i,(i==4)?2:0,0);
      for (int i = 1; i <= 2; i++)  add("rinse3", 0,0,1,1, 1,1,10-i,20,20,2,0);
      // ---- Test 4: power off mid-rinse and priority ----
      add("pwr_off",    1,0,0,1, 0,0,0,0,0,0,0);
      add("off_ignore", 0,1,1,1, 0,0,0,0,0,0,0);
      add("pwr_on_m1",  1,0,0,1, 1,0,10,10,0,0,0);
      add("pwr_vs_st",  1,1,0,1, 0,0,0,0,0,0,0);
      add("pwr_on_m1b", 1,0,0,1, 1,0,10,10,0,0,0);
      add("start_m1",   0,1,0,1, 1,1,10,10,0,0,0);
      add("fill_m1",    0,0,1,1, 1,1,10,10,5,0,0);

      // Reset state, checked before any clock edge has been seen.
      #2;
      compare("reset_state", 27'd0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) apply(vecs[i]);

      // Asynchronous reset mid-FILL, away from any clock edge.
      #3;
      rst_n = 1'b0;
      #1;
      compare("async_reset", 27'd0);
      @(negedge clk);
      rst_n = 1'b1;
      apply(mk("post_reset_pwr", 1,0,0,1, 1,0,10,10,0,0,0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
